rtc_snapshot_reader: RTL

// - Bus initiator that reads the 24-bit RTC counter (0x2009..0x200B, LSB first) and returns one coherent snapshot.
// - Used by the savestate/host-sync path; arbitrates for the CPU register bus with a request/ack handshake.
// - Issues reads only; never writes RTC control (0x2008).

---
 rtl/rtc_snapshot_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rtc_snapshot_reader.sv
// Bus initiator that reads the 24-bit RTC counter byte by byte and returns one coherent snapshot.
// Build option RTC_SNAP_RETRY_EN adds a re-read of the low byte to detect tearing, with a bounded retry loop.
module rtc_snapshot_reader #(
   parameter logic [23:0] BASE_ADDR   = 24'h2009,
   parameter int          MAX_RETRIES = 3
) (
   input  logic        clk,
   input  logic        clk_ce,
   input  logic        reset,
   input  logic        req_start,
   output logic        busy,
   output logic        snap_valid,
   output logic [23:0] snap_value,
   output logic        snap_torn,
   output logic        bus_request,
   input  logic        bus_ack,
   output logic [23:0] bus_address_out,
   output logic        bus_write,
   input  logic [7:0]  bus_data_in
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_RD_LO, S_RD_MID, S_RD_HI, S_RD_CHK
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_complete;
   logic [7:0]  r_lo;
   logic [7:0]  r_mid;
   logic        r_snap_valid;
   logic [23:0] r_snap_value;
   logic [23:0] w_snap_word;

`ifdef RTC_SNAP_RETRY_EN
   localparam logic [3:0] LP_MAX_RETRIES = 4'(MAX_RETRIES);
   logic [7:0]  r_hi;
   logic [3:0]  r_retries;
   logic        r_snap_torn;
   logic        w_retry;
   logic        w_torn;
   assign w_snap_word = {r_hi, r_mid, r_lo};
   assign snap_torn   = r_snap_torn;
`else
   logic        w_unused_cfg;
   assign w_unused_cfg = (MAX_RETRIES != 0);
   // Without the check pass the high byte is taken straight off the bus on the final read.
   assign w_snap_word  = {bus_data_in, r_mid, r_lo};
   assign snap_torn    = 1'b0;
`endif

   assign snap_valid = r_snap_valid;
   assign snap_value = r_snap_value;
   assign bus_write  = 1'b0;

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else if (clk_ce)
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_complete  = 1'b0;
`ifdef RTC_SNAP_RETRY_EN
      w_retry     = 1'b0;
      w_torn      = 1'b0;
`endif
      case (r_state)
         S_IDLE:   if (req_start) w_state_nxt = S_REQ;
         S_REQ:    if (bus_ack)   w_state_nxt = S_RD_LO;
         S_RD_LO:  if (bus_ack)   w_state_nxt = S_RD_MID;
         S_RD_MID: if (bus_ack)   w_state_nxt = S_RD_HI;
         S_RD_HI: begin
            if (bus_ack) begin
`ifdef RTC_SNAP_RETRY_EN
               w_state_nxt = S_RD_CHK;
`else
               w_state_nxt = S_IDLE;
               w_complete  = 1'b1;
`endif
            end
         end
`ifdef RTC_SNAP_RETRY_EN
         S_RD_CHK: begin
            if (bus_ack) begin
               if (bus_data_in == r_lo) begin
                  w_state_nxt = S_IDLE;
                  w_complete  = 1'b1;
               end else if (r_retries < LP_MAX_RETRIES) begin
                  w_state_nxt = S_RD_LO;
                  w_retry     = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_complete  = 1'b1;
                  w_torn      = 1'b1;
               end
            end
         end
`endif
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy            = (r_state != S_IDLE);
      bus_request     = (r_state != S_IDLE);
      bus_address_out = 24'h0;
      case (r_state)
         S_RD_LO, S_RD_CHK: bus_address_out = BASE_ADDR;
         S_RD_MID:          bus_address_out = BASE_ADDR + 24'd1;
         S_RD_HI:           bus_address_out = BASE_ADDR + 24'd2;
         default:           bus_address_out = 24'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_snap_valid <= 1'b0;
         r_snap_value <= 24'h0;
         r_lo         <= 8'h0;
         r_mid        <= 8'h0;
`ifdef RTC_SNAP_RETRY_EN
         r_hi         <= 8'h0;
         r_retries    <= 4'h0;
         r_snap_torn  <= 1'b0;
`endif
      end else if (clk_ce) begin
         r_snap_valid <= w_complete;
         if (w_complete)
            r_snap_value <= w_snap_word;
         if (bus_ack) begin
            case (r_state)
               S_RD_LO:  r_lo  <= bus_data_in;
               S_RD_MID: r_mid <= bus_data_in;
`ifdef RTC_SNAP_RETRY_EN
               S_RD_HI:  r_hi  <= bus_data_in;
`endif
               default:  ;
            endcase
         end
`ifdef RTC_SNAP_RETRY_EN
         r_snap_torn <= w_complete & w_torn;
         if (w_complete)
            r_retries <= 4'h0;
         else if (w_retry)
            r_retries <= r_retries + 4'd1;
`endif
      end
   end

endmodule
